// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Generates per-stage write enables and flush controls from load-use hazards,
// EX-stage redirects and data-memory wait states. It also runs a memory-wait
// watchdog and keeps saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_flush,
  output logic             mem_busy,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // The wait counter only has to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  logic [0:0]        state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              timeout_err_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;

  logic load_use_s;
  logic timeout_now_s;
  logic mem_stall_s;
  logic redirect_act_s;
  logic stall_evt_s;

  // Hazard detection terms.
  always_comb begin
    load_use_s = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                  (id_uses_rs2 && (ex_rd == id_rs2)));
    timeout_now_s  = (state_r == ST_MEM_WAIT) && (wait_cnt_r == WAIT_LAST);
    mem_stall_s    = mem_req && !mem_ready && !timeout_now_s;
    // A redirect that meets a memory freeze stays in EX and acts after release.
    redirect_act_s = ex_redirect && !mem_stall_s;
    // A redirect squashes the dependent ID instruction, so load-use is moot then.
    stall_evt_s    = mem_stall_s || (load_use_s && !ex_redirect);
  end

  // Pipeline register controls, by priority: reset, memory freeze, redirect, load-use.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_flush = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_write  = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mem_stall_s) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use_s) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_flush  = 1'b1;
    end else begin
      pc_write     = 1'b1;
    end
  end

  // Memory-wait FSM with watchdog; a reset during a wait simply abandons it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= WAIT_ZERO;
      timeout_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_stall_s) begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= WAIT_ONE;
          end else begin
            state_r    <= ST_RUN;
            wait_cnt_r <= WAIT_ZERO;
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_req || mem_ready) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= WAIT_ZERO;
          end else if (timeout_now_s) begin
            state_r       <= ST_RUN;
            wait_cnt_r    <= WAIT_ZERO;
            timeout_err_r <= 1'b1;
          end else begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
          end
        end
        default: begin
          state_r    <= ST_RUN;
          wait_cnt_r <= WAIT_ZERO;
        end
      endcase
    end
  end

  // Saturating performance counters for stall cycles and redirect flushes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_evt_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (redirect_act_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign mem_busy        = (state_r == ST_MEM_WAIT);
  assign mem_timeout_err = timeout_err_r;
  assign stall_cycles    = stall_cnt_r;
  assign flush_count     = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// random traffic, compared cycle by cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MT   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic          mem_req, mem_ready;
  logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic          ex_mem_write, mem_wb_flush, mem_busy, mem_timeout_err;
  logic [CW-1:0] stall_cycles, flush_count;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .mem_wb_flush(mem_wb_flush),
    .mem_busy(mem_busy), .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: length of the current memory-freeze run, sticky error, counters.
  int stall_run = 0;
  bit m_err     = 1'b0;
  int m_stall   = 0;
  int m_flush   = 0;
  bit regs_ok   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    bit lu, tmo, ms, act_redirect, act_lu;
    logic [6:0] exp_ctrl;
    lu  = ex_mem_read && (ex_rd != 5'd0) &&
          ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
    tmo = (stall_run == MT - 1);
    ms  = mem_req && !mem_ready && !tmo;
    act_redirect = !ms && ex_redirect;
    act_lu       = !ms && !ex_redirect && lu;
    // order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush
    if (!rst_n)            exp_ctrl = 7'b0010101;
    else if (ms)           exp_ctrl = 7'b0000001;
    else if (act_redirect) exp_ctrl = 7'b1111110;
    else if (act_lu)       exp_ctrl = 7'b0001110;
    else                   exp_ctrl = 7'b1101010;
    @(negedge clk);
    chk("ctrl", 32'({pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                     ex_mem_write, mem_wb_flush}), 32'(exp_ctrl));
    if (regs_ok) begin
      chk("mem_busy", 32'(mem_busy), 32'(stall_run > 0));
      chk("timeout_err", 32'(mem_timeout_err), 32'(m_err));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
      chk("flush_count", 32'(flush_count), 32'(m_flush));
    end
    if (!rst_n) begin
      stall_run = 0; m_err = 1'b0; m_stall = 0; m_flush = 0; regs_ok = 1'b1;
    end else begin
      if (tmo && mem_req && !mem_ready) m_err = 1'b1;
      stall_run = ms ? stall_run + 1 : 0;
      if ((ms || act_lu) && m_stall < CMAX) m_stall++;
      if (act_redirect && m_flush < CMAX) m_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    rst_n = 1'b1;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    // Reset held for three cycles with a pending memory request.
    mem_req = 1'b1;
    do_reset(3);
    idle();
    cycle();
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_err", 32'(mem_timeout_err), 32'd0);
    chk("rst_busy", 32'(mem_busy), 32'd0);

    // Load-use on rs2, followed by the bubble cycle.
    set_load_use(); cycle();
    idle(); cycle();
    chk("lu_stall", 32'(stall_cycles), 32'd1);
    // Same shape but rd = x0: no hazard.
    set_load_use(); ex_rd = 5'd0; id_rs2 = 5'd0; cycle();
    idle(); cycle();
    chk("lu_x0_stall", 32'(stall_cycles), 32'd1);

    // Redirect overrides load-use.
    set_load_use(); ex_redirect = 1'b1; cycle();
    idle(); cycle();
    chk("redir_flush", 32'(flush_count), 32'd1);
    chk("redir_stall", 32'(stall_cycles), 32'd1);

    // Memory wait of three cycles, redirect held during the wait, release on ready.
    mem_req = 1'b1; mem_ready = 1'b0; cycle();
    ex_redirect = 1'b1; cycle(); cycle();
    chk("wait_flush_held", 32'(flush_count), 32'd1);
    mem_ready = 1'b1; cycle();
    idle(); cycle();
    chk("wait_stall", 32'(stall_cycles), 32'd4);
    chk("wait_flush", 32'(flush_count), 32'd2);
    chk("wait_err", 32'(mem_timeout_err), 32'd0);

    // Watchdog: four frozen cycles, forced release on the fifth.
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < MT; i++) cycle();
    idle();
    for (int i = 0; i < 3; i++) cycle();
    chk("wd_err", 32'(mem_timeout_err), 32'd1);
    do_reset(1);
    cycle();
    chk("wd_err_cleared", 32'(mem_timeout_err), 32'd0);

    // Reset in the middle of a wait aborts it without flagging an error.
    mem_req = 1'b1; mem_ready = 1'b0; cycle(); cycle();
    do_reset(1);
    idle(); cycle();
    chk("abort_err", 32'(mem_timeout_err), 32'd0);
    chk("abort_busy", 32'(mem_busy), 32'd0);

    // Saturation: twenty load-use events on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      set_load_use(); cycle();
      idle(); cycle();
    end
    chk("sat_stall", 32'(stall_cycles), 32'd15);

    // Random traffic against the model.
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      rst_n       = ($urandom_range(0, 60) != 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 4) == 0);
      mem_req     = ($urandom_range(0, 3) != 0);
      mem_ready   = ($urandom_range(0, 4) == 0);
      cycle();
    end
    idle(); rst_n = 1'b1; cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
